flo_seq: RTL and testbench
==========================

FLO_SEQ -- requirements
Module: flo_seq

Interface
REQ-001 SHALL have parameter WID, default 96: width of the search vector, minimum 2.
REQ-002 SHALL have parameter SEG, default 16: bits examined per scan cycle, 1 <= SEG <= WID.
REQ-003 SHALL have derived constants NSEG = ceil(WID/SEG) and OW = $clog2(WID+1), where OW is the index width (7 for WID=96).
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1: request present.
REQ-007 SHALL have port i_ready, output, 1: block accepts a request.
REQ-008 SHALL have port i, input, WID: vector to search.
REQ-009 SHALL have port i_dir, input, 1: 0 = lowest matching index (find last), 1 = highest matching index (find first).
REQ-010 SHALL have port i_pol, input, 1: 1 = search for ones, 0 = search for zeros.
REQ-011 SHALL have port o_valid, output, 1: result present.
REQ-012 SHALL have port o_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port o, output, OW: matching bit index, all ones when there is no match.
REQ-014 SHALL have port o_found, output, 1: a match exists.

Function
REQ-015 SHALL implement states IDLE, SCAN and DONE.
REQ-016 SHALL drive i_ready = 1 only in IDLE; o_valid = 1 only in DONE.
REQ-017 SHALL, on the edge where i_valid && i_ready, capture i, i_dir and i_pol and enter SCAN with segment counter k = 1.
REQ-018 SHALL number segments by bit range: segment s covers bits [s*SEG, min(s*SEG+SEG, WID)-1].
REQ-019 SHALL scan segments in order s = 0..NSEG-1 when dir = 0, and s = NSEG-1..0 when dir = 1.
REQ-020 SHALL examine exactly one segment per SCAN cycle.
REQ-021 SHALL treat a bit as matching when it equals pol.
REQ-022 SHALL treat pad bits of a partial final segment (index >= WID) as never matching, for either pol.
REQ-023 SHALL, when the examined segment contains a match, register o as the absolute index (lowest in that segment if dir = 0, highest if dir = 1) and set o_found = 1, then enter DONE on that edge.
REQ-024 SHALL, when the k-th examined segment has no match and k = NSEG, register o = all ones and o_found = 0, then enter DONE.
REQ-025 SHALL otherwise increment k and remain in SCAN.
REQ-026 SHALL give a latency from the accept edge to o_valid rising of exactly k edges, where k is the 1-based scan position of the first hit segment, or NSEG if there is no hit.
REQ-027 SHALL hold o, o_found and o_valid stable in DONE until o_ready = 1.
REQ-028 SHALL, on an edge in DONE with o_ready = 1, return to IDLE; the next request is accepted no earlier than the following edge.
REQ-029 SHALL ignore i_valid while in SCAN or DONE.
REQ-030 SHALL make captured operands immune to later changes on i, i_dir and i_pol.
REQ-031 SHALL compute the result combinationally from the captured vector only; no multi-cycle paths.

Reset
REQ-032 SHALL, while rst_n = 0 (asynchronously), force state IDLE, k = 0, o_valid = 0, o = all ones, o_found = 0 and i_ready = 1 once out of reset.
REQ-033 SHALL abandon any in-flight scan or held result on reset without producing an o_valid pulse.

Verification (WID=96, SEG=16, NSEG=6 unless noted)
REQ-034 SHALL be verified for: i = 1<<50, dir = 0, pol = 1 -> o = 50, o_found = 1, o_valid 4 edges after accept.
REQ-035 SHALL be verified for: i = 0, dir = 0, pol = 1 -> o = 127, o_found = 0, latency 6; repeat with dir = 1 gives the same result.
REQ-036 SHALL be verified for: bits 0 and 95 set, dir = 1, pol = 1 -> o = 95, latency 1; same vector with dir = 0 -> o = 0, latency 1.
REQ-037 SHALL be verified for: all ones except bit 7, pol = 0, dir = 0 -> o = 7, latency 1; then WID = 100, i = all ones, pol = 0 -> o = 127, o_found = 0, latency 7 (pad bits are not matched).
REQ-038 SHALL be verified for: o_ready held low 5 cycles in DONE -> o, o_found and o_valid stable and i_ready = 0 throughout; o_ready = 1 -> IDLE next edge.
REQ-039 SHALL be verified for: rst_n pulsed low mid-SCAN, with i changed during the scan -> outputs reset immediately, no o_valid, and the next request produces a correct result.

Source files
------------

// File: rtl/flo_seq.sv
// flo_seq: sequential find-first/last one/zero search.
// Scans one SEG-bit segment per cycle and stops at the first segment that holds a match.
module flo_seq #(
   parameter  int WID  = 96,
   parameter  int SEG  = 16,
   localparam int NSEG = (WID + SEG - 1) / SEG,
   localparam int OW   = $clog2(WID + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_valid,
   output logic           i_ready,
   input  logic [WID-1:0] i,
   input  logic           i_dir,
   input  logic           i_pol,
   output logic           o_valid,
   input  logic           o_ready,
   output logic [OW-1:0]  o,
   output logic           o_found
);
   localparam int KW = $clog2(NSEG + 1);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t                state, state_n;
   logic [KW-1:0]         k, k_n, s;
   logic [WID-1:0]        vec;
   logic                  dir, pol, load, hit, found_n;
   logic [NSEG*SEG-1:0]   m;
   logic [SEG-1:0]        seg;
   logic [OW-1:0]         o_n;
   int                    idx;
   assign i_ready = state == IDLE;
   assign o_valid = state == DONE;
   // pad bits beyond WID stay zero so they can never match
   always_comb begin
      m = '0;
      m[WID-1:0] = pol ? vec : ~vec;
   end
   assign s   = dir ? KW'(NSEG) - k : k - KW'(1);
   assign seg = m[s*SEG +: SEG];
   always_comb begin
      hit = 1'b0;
      idx = 0;
      for (int j = 0; j < SEG; j++)
         if (seg[j] && (dir || !hit)) begin
            hit = 1'b1;
            idx = j;
         end
   end
   always_comb begin
      state_n = state;
      k_n     = k;
      o_n     = o;
      found_n = o_found;
      load    = 1'b0;
      case (state)
         IDLE: if (i_valid) begin
            load    = 1'b1;
            k_n     = KW'(1);
            state_n = SCAN;
         end
         SCAN: if (hit) begin
            o_n     = OW'(int'(s) * SEG + idx);
            found_n = 1'b1;
            state_n = DONE;
         end else if (k == KW'(NSEG)) begin
            o_n     = '1;
            found_n = 1'b0;
            state_n = DONE;
         end else k_n = k + KW'(1);
         DONE: if (o_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         k       <= '0;
         o       <= '1;
         o_found <= 1'b0;
         vec     <= '0;
         dir     <= 1'b0;
         pol     <= 1'b0;
      end else begin
         state   <= state_n;
         k       <= k_n;
         o       <= o_n;
         o_found <= found_n;
         if (load) begin
            vec <= i;
            dir <= i_dir;
            pol <= i_pol;
         end
      end
   end
endmodule

// File: tb/tb_flo_seq.sv
// tb_flo_seq: directed and randomized checks of flo_seq against a whole-vector search model.
module tb_flo_seq;
   localparam int WID = 96, SEG = 16, NSEG = 6;
   logic clk = 0, rst_n = 0;
   logic i_valid = 0, i_dir = 0, i_pol = 0, o_ready = 0;
   logic i_ready, o_valid, o_found;
   logic [WID-1:0] i = '0;
   logic [6:0] o;
   logic b_iv = 0, b_dir = 0, b_pol = 0, b_or = 0, b_ir, b_ov, b_f;
   logic [99:0] b_i = '0;
   logic [6:0] b_o;
   int nchk = 0, nfail = 0, exp_o = 127, exp_f = 0;

   flo_seq #(.WID(WID), .SEG(SEG)) dut (.clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
      .i(i), .i_dir(i_dir), .i_pol(i_pol), .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_found(o_found));
   flo_seq #(.WID(100), .SEG(16)) dut100 (.clk(clk), .rst_n(rst_n), .i_valid(b_iv), .i_ready(b_ir),
      .i(b_i), .i_dir(b_dir), .i_pol(b_pol), .o_valid(b_ov), .o_ready(b_or), .o(b_o), .o_found(b_f));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // whole-vector search: index of the wanted extreme match, and the scan position of its segment
   function automatic void model(input logic [WID-1:0] v, input logic d, input logic p,
                                 output int eo, output int ef, output int el);
      int pos = -1;
      if (!d) begin
         for (int b = 0; b < WID; b++) if (v[b] == p) begin pos = b; break; end
      end else begin
         for (int b = WID - 1; b >= 0; b--) if (v[b] == p) begin pos = b; break; end
      end
      ef = pos >= 0 ? 1 : 0;
      eo = pos >= 0 ? pos : 127;
      el = pos < 0 ? NSEG : (d ? NSEG - pos / SEG : pos / SEG + 1);
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_o", o, 127);
         chk("rst_found", o_found, 0);
         chk("rst_ovalid", o_valid, 0);
         chk("rst_iready", i_ready, 1);
      end else if (o_valid) begin
         chk("o", o, exp_o);
         chk("found", o_found, exp_f);
         chk("iready_in_done", i_ready, 0);
      end
   end

   task automatic run(input logic [WID-1:0] v, input logic d, input logic p, input int hold);
      int el, lat;
      logic [6:0] o0;
      @(negedge clk);
      chk("iready_idle", i_ready, 1);
      model(v, d, p, exp_o, exp_f, el);
      i = v; i_dir = d; i_pol = p; i_valid = 1; o_ready = 0;
      @(posedge clk); #1;
      i_valid = 0;
      i = {$urandom, $urandom, $urandom}; i_dir = 1'($urandom); i_pol = 1'($urandom);
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!o_valid && lat < 20);
      chk("latency", lat, el);
      o0 = o;
      repeat (hold) begin
         @(posedge clk); #1;
         chk("hold_ovalid", o_valid, 1);
         chk("hold_iready", i_ready, 0);
         chk("hold_o", o, o0);
      end
      o_ready = 1;
      @(posedge clk); #1;
      chk("release_ovalid", o_valid, 0);
      chk("release_iready", i_ready, 1);
      o_ready = 0;
   endtask

   task automatic run100(input logic [99:0] v, input logic d, input logic p, input int eo, input int ef, input int el);
      int lat = 0;
      @(negedge clk);
      b_i = v; b_dir = d; b_pol = p; b_iv = 1;
      @(posedge clk); #1;
      b_iv = 0; b_i = '0;
      do begin @(posedge clk); #1; lat++; end while (!b_ov && lat < 20);
      chk("w100_latency", lat, el);
      chk("w100_o", b_o, eo);
      chk("w100_found", b_f, ef);
      b_or = 1;
      @(posedge clk); #1;
      b_or = 0;
   endtask

   initial begin
      int eo, ef, el, mode, pos;
      logic [WID-1:0] v;
      repeat (3) @(negedge clk);
      rst_n = 1;
      v = '0; v[50] = 1;
      model(v, 0, 1, eo, ef, el);
      chk("pin_50_o", eo, 50); chk("pin_50_lat", el, 4);
      run(v, 0, 1, 0);
      model('0, 1, 1, eo, ef, el);
      chk("pin_zero_o", eo, 127); chk("pin_zero_f", ef, 0); chk("pin_zero_lat", el, 6);
      run('0, 0, 1, 0);
      run('0, 1, 1, 0);
      v = '0; v[0] = 1; v[95] = 1;
      model(v, 1, 1, eo, ef, el);
      chk("pin_95_o", eo, 95); chk("pin_95_lat", el, 1);
      run(v, 1, 1, 0);
      run(v, 0, 1, 0);
      v = '1; v[7] = 0;
      model(v, 0, 0, eo, ef, el);
      chk("pin_z7_o", eo, 7); chk("pin_z7_lat", el, 1);
      run(v, 0, 0, 5);
      run100('1, 0, 0, 127, 0, 7);
      run100('1, 1, 0, 127, 0, 7);
      run100(100'd1 << 99, 1, 1, 99, 1, 1);
      // reset in the middle of a scan, with the input bus disturbed
      @(negedge clk);
      v = '0; v[90] = 1;
      i = v; i_dir = 0; i_pol = 1; i_valid = 1;
      @(posedge clk); #1;
      i_valid = 0; i = '1;
      repeat (2) @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_ovalid", o_valid, 0);
      chk("arst_o", o, 127);
      chk("arst_iready", i_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (8) begin @(posedge clk); #1; chk("post_rst_no_ovalid", o_valid, 0); end
      run(v, 0, 1, 0);
      for (int n = 0; n < 60; n++) begin
         mode = $urandom_range(0, 3);
         pos = $urandom_range(0, WID - 1);
         v = mode == 0 ? WID'({$urandom, $urandom, $urandom}) : mode == 2 ? '0 : mode == 3 ? '1 : '0;
         if (mode == 1) v[pos] = 1;
         if (mode == 3) v[pos] = 0;
         run(v, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
      end
      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end
endmodule
